spi_miso_tx: RTL and testbench

//  SPI mode-0 slave transmitter: the MISO-side counterpart of spi_reader. Drives status/readback bytes to the MCU.

---
 rtl/spi_miso_tx.sv | 195 +++++++++++++++++++
 tb/tb_spi_miso_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_miso_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_miso_tx
// Description : SPI mode-0 slave transmitter running in the sys_clock domain.
//               spi_sck/spi_cs are oversampled through synchronizers. Bytes
//               are shifted out MSB first from a one-entry valid/ready holding
//               buffer. FILL_BYTE is sent when the buffer is empty at a byte
//               boundary.
//               Optional feature macro: SPI_TX_UNDERRUN_CNT_EN (saturating
//               underrun counter on underrun_cnt; tied to zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_miso_tx #(
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       sys_clock,
    input  logic       sys_reset_n,
    input  logic       spi_sck,
    input  logic       spi_cs,
    output logic       spi_miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       byte_done,
    output logic       underrun,
    output logic [7:0] underrun_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] C_LAST_BIT = 3'd7;

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,  cs_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q,  cs_prev_d;

    // Transmit datapath and control
    state_t     state_q,     state_d;
    logic [7:0] shift_q,     shift_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic       buf_full_q,  buf_full_d;
    logic [7:0] buf_data_q,  buf_data_d;
    logic       byte_done_q, byte_done_d;
    logic       underrun_q,  underrun_d;

    logic sck_s;
    logic cs_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;
    logic load_now;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s &  sck_prev_q;
    assign cs_fall  = ~cs_s  &  cs_prev_q;
    assign cs_rise  =  cs_s  & ~cs_prev_q;

    // Shift raw pins into the synchronizers; the last stage feeds edge detect
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0],  spi_cs};
        sck_prev_d = sck_s;
        cs_prev_d  = cs_s;
    end

    // Next-state logic: buffer write, state transitions, shift and load
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        buf_full_d  = buf_full_q;
        buf_data_d  = buf_data_q;
        byte_done_d = 1'b0;
        underrun_d  = 1'b0;
        load_now    = 1'b0;

        // A byte offered while the buffer is empty is captured; this is
        // decided before the load so a same-cycle load never bypasses it.
        if (tx_valid && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_data_d = tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d  = ST_SHIFT;
                    load_now = 1'b1;
                end
            end
            ST_SHIFT: begin
                // CS deassertion takes priority over any coincident SCK edge
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    byte_done_d = (bit_cnt_q == C_LAST_BIT);
                end else if (sck_fall) begin
                    // Count wrapped to zero: byte complete, reload at once
                    if (bit_cnt_q == 3'd0) begin
                        load_now = 1'b1;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_now) begin
            bit_cnt_d = 3'd0;
            if (buf_full_q) begin
                shift_d    = buf_data_q;
                buf_full_d = 1'b0;
            end else begin
                shift_d    = FILL_BYTE;
                underrun_d = 1'b1;
            end
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            buf_full_q  <= 1'b0;
            buf_data_q  <= 8'h00;
            byte_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            buf_full_q  <= buf_full_d;
            buf_data_q  <= buf_data_d;
            byte_done_q <= byte_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_miso  = (state_q == ST_SHIFT) & shift_q[7];
    assign miso_oe   = (state_q == ST_SHIFT);
    assign tx_ready  = ~buf_full_q;
    assign byte_done = byte_done_q;
    assign underrun  = underrun_q;

`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [7:0] urun_cnt_q, urun_cnt_d;

    // Count underrun pulses, holding at the maximum value
    always_comb begin
        urun_cnt_d = urun_cnt_q;
        if (underrun_q && (urun_cnt_q != 8'hFF)) begin
            urun_cnt_d = urun_cnt_q + 8'd1;
        end
    end

    // Underrun counter register; cleared only by reset
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            urun_cnt_q <= 8'h00;
        end else begin
            urun_cnt_q <= urun_cnt_d;
        end
    end

    assign underrun_cnt = urun_cnt_q;
`else
    assign underrun_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_miso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_miso_tx
// Description : Directed self-checking bench for spi_miso_tx. A bench-side
//               model predicts transmitted bytes from a push queue, tracks
//               pulse totals, and predicts miso_oe as the CS pin delayed by
//               the synchronizer latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_miso_tx;

    localparam logic [7:0] FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sck;
    logic       spi_cs;
    logic       spi_miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       byte_done;
    logic       underrun;
    logic [7:0] underrun_cnt;

    spi_miso_tx #(
        .FILL_BYTE   (FILL),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clock    (clk),
        .sys_reset_n  (rst_n),
        .spi_sck      (spi_sck),
        .spi_cs       (spi_cs),
        .spi_miso     (spi_miso),
        .miso_oe      (miso_oe),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .byte_done    (byte_done),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    logic [7:0] model_q[$];
    logic [7:0] rx_log[$];
    int exp_bd = 0;
    int exp_ur = 0;
    int ur_rst = 0;
    int n_bd   = 0;
    int n_ur   = 0;
    bit p0 = 1'b1, p1 = 1'b1, p2 = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef SPI_TX_UNDERRUN_CNT_EN
        return (ur_rst > 255) ? 32'd255 : ur_rst;
`else
        return 32'd0;
`endif
    endfunction

    // CS pin history sampled at each clock edge; the DUT acts on it two
    // edges after the first sampling edge
    always @(posedge clk) begin
        if (!rst_n) begin
            p0 = 1'b1; p1 = 1'b1; p2 = 1'b1;
        end else begin
            p2 = p1; p1 = p0; p0 = spi_cs;
        end
    end

    // Per-cycle compare and pulse counting
    always @(negedge clk) begin
        bit exp_oe;
        exp_oe = rst_n ? !p2 : 1'b0;
        if (byte_done) n_bd++;
        if (underrun)  n_ur++;
        chk("miso_oe_cycle", miso_oe, exp_oe);
        if (!exp_oe) chk("miso_idle_low", spi_miso, 1'b0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_load(output logic [7:0] b);
        if (model_q.size() > 0) begin
            b = model_q.pop_front();
        end else begin
            b = FILL;
            exp_ur++;
            ur_rst++;
        end
    endtask

    task automatic push(input logic [7:0] v);
        int n;
        n = 0;
        while (!tx_ready && n < 50) begin
            cyc(1);
            n++;
        end
        chk("push_ready_wait", tx_ready, 1'b1);
        tx_data  = v;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        model_q.push_back(v);
    endtask

    // One SCK period (8 sys clocks); master samples MISO at the rising edge
    task automatic sck_bit(inout logic [7:0] rx, input bit last);
        cyc(4);
        rx = {rx[6:0], spi_miso};
        spi_sck = 1'b1;
        cyc(4);
        spi_sck = 1'b0;
        if (last) spi_cs = 1'b1;
    endtask

    task automatic xfer(input int nbytes, input int nbits, input bit mid_push, input logic [7:0] mid_val);
        logic [7:0] rx;
        logic [7:0] exp_b;
        spi_cs = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            model_load(exp_b);
            rx = 8'h00;
            for (int b = 0; b < nbits; b++) begin
                if (mid_push && i == 0 && b == 3) push(mid_val);
                sck_bit(rx, (i == nbytes - 1) && (b == nbits - 1));
            end
            if (nbits == 8) begin
                exp_bd++;
                rx_log.push_back(rx);
            end
            chk("miso_bits", rx, exp_b >> (8 - nbits));
        end
        cyc(3);
        chk("oe_off_3cyc", miso_oe, 1'b0);
        cyc(3);
        chk("byte_done_total", n_bd, exp_bd);
        chk("underrun_total", n_ur, exp_ur);
        chk("underrun_cnt", underrun_cnt, exp_cnt());
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tx_ready"},  tx_ready, 1'b1);
        chk({tag, "_miso"},      spi_miso, 1'b0);
        chk({tag, "_oe"},        miso_oe, 1'b0);
        chk({tag, "_byte_done"}, byte_done, 1'b0);
        chk({tag, "_underrun"},  underrun, 1'b0);
        chk({tag, "_cnt"},       underrun_cnt, 8'h00);
    endtask

    initial begin
        int bd0, ur0;
        logic [7:0] rx;
        logic [7:0] b5;

        rst_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        cyc(3);
        check_reset_vals("rst");
        rst_n = 1'b1;
        cyc(3);

        // 1: single byte 0xA5
        push(8'hA5);
        chk("t1_ready_low", tx_ready, 1'b0);
        bd0 = n_bd; ur0 = n_ur;
        xfer(1, 8, 1'b0, 8'h00);
        chk("t1_byte", rx_log[rx_log.size()-1], 8'hA5);
        chk("t1_bd", n_bd - bd0, 1);
        chk("t1_ur", n_ur - ur0, 0);
        chk("t1_ready", tx_ready, 1'b1);

        // 2: empty buffer gives fill byte and one underrun
        ur0 = n_ur;
        xfer(1, 8, 1'b0, 8'h00);
        chk("t2_byte", rx_log[rx_log.size()-1], 8'hFF);
        chk("t2_ur_once", n_ur - ur0, 1);

        // 3: back-to-back with a push during bit 3
        push(8'h3C);
        bd0 = n_bd; ur0 = n_ur;
        xfer(2, 8, 1'b1, 8'hC3);
        chk("t3_byte0", rx_log[rx_log.size()-2], 8'h3C);
        chk("t3_byte1", rx_log[rx_log.size()-1], 8'hC3);
        chk("t3_bd", n_bd - bd0, 2);
        chk("t3_ur", n_ur - ur0, 0);

        // 4: abort after 3 bits, buffer kept across transactions
        push(8'h81);
        bd0 = n_bd;
        xfer(1, 3, 1'b0, 8'h00);
        chk("t4_no_bd", n_bd - bd0, 0);
        push(8'h42);
        chk("t4_ready_low", tx_ready, 1'b0);
        tx_data = 8'h99;
        tx_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("t4_stall", tx_ready, 1'b0);
        end
        tx_valid = 1'b0;
        xfer(1, 8, 1'b0, 8'h00);
        chk("t4_byte", rx_log[rx_log.size()-1], 8'h42);

        // 5: reset in the middle of 0x5A with 0x77 buffered
        push(8'h5A);
        spi_cs = 1'b0;
        model_load(b5);
        cyc(5);
        push(8'h77);
        rx = 8'h00;
        for (int b = 0; b < 4; b++) sck_bit(rx, 1'b0);
        chk("t5_partial", rx, 8'h05);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t5_rst");
        model_q.delete();
        ur_rst = 0;
        spi_cs = 1'b1;
        spi_sck = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        xfer(1, 8, 1'b0, 8'h00);
        chk("t5_byte", rx_log[rx_log.size()-1], 8'hFF);

        // 6: long underrun run saturates the counter when enabled
        ur0 = n_ur;
        xfer(300, 8, 1'b0, 8'h00);
        chk("t6_ur", n_ur - ur0, 300);
`ifdef SPI_TX_UNDERRUN_CNT_EN
        chk("t6_cnt_sat", underrun_cnt, 8'd255);
`else
        chk("t6_cnt_zero", underrun_cnt, 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
